rotcnt_issue: RTL and testbench

Command issue stage that sits directly upstream of the rotate-or-count stage. It buffers {A, B, rotate} commands from a producer in a small FIFO and presents them to the stage one per cycle. It also tags each command so the stage's registered R output can be returned to the producer with a result-valid strobe. It does not compute R itself.

---
 rtl/rotcnt_pkg.sv | 30 +++
 rtl/rotcnt_fifo.sv | 68 ++++++
 rtl/rotcnt_issue.sv | 92 +++++++++
 tb/tb_rotcnt_issue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rotcnt_pkg.sv
// Shared types and the reference rotate-or-count function for the issue stage
// and its downstream datapath.
package rotcnt_pkg;

  localparam int unsigned A_W = 4;
  localparam int unsigned B_W = 2;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           rotate;
  } cmd_t;

  // Rotate right by (b + 2) places, or increment modulo 2**A_W.
  function automatic logic [A_W-1:0] rotcnt_model(input logic [A_W-1:0] a,
                                                  input logic [B_W-1:0] b,
                                                  input logic           rotate);
    logic [A_W-1:0] r;
    r = a;
    if (rotate) begin
      r = a + A_W'(1);
    end else begin
      for (int i = 0; i < int'(b) + 2; i++) begin
        r = {r[0], r[A_W-1:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rotcnt_fifo.sv
// Command FIFO: wrap-around pointers plus a separate occupancy count, with a
// synchronous flush that discards any same-edge push or pop.
module rotcnt_fifo
  import rotcnt_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  cmd_t            data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output cmd_t            data_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rotcnt_issue.sv
// Issue stage: buffers commands, presents one per cycle to the rotate-or-count
// stage and tags the stage's registered result with a valid strobe.
module rotcnt_issue
  import rotcnt_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [A_W-1:0]  in_a,
  input  logic [B_W-1:0]  in_b,
  input  logic            in_rotate,
  input  logic            issue_en,
  input  logic            flush,
  output logic [A_W-1:0]  op_a,
  output logic [B_W-1:0]  op_b,
  output logic            op_rotate,
  output logic            op_fire,
  input  logic [A_W-1:0]  res_in,
  output logic            res_valid,
  output logic [A_W-1:0]  res_data,
  output logic            res_rotate,
  output logic [CntW-1:0] count,
  output logic [7:0]      issued
);

  cmd_t       push_cmd, head_cmd;
  logic       full, empty, issue;
  cmd_t       op_q, op_d;
  logic       op_fire_q, op_fire_d;
  logic       res_valid_q, res_valid_d;
  logic       res_rotate_q, res_rotate_d;
  logic [7:0] issued_q, issued_d;

  assign push_cmd = '{a: in_a, b: in_b, rotate: in_rotate};
  assign issue    = ~empty & issue_en & ~flush;

  rotcnt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (in_valid),
    .data_i  (push_cmd),
    .pop_i   (issue),
    .flush_i (flush),
    .data_o  (head_cmd),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // op_* hold their last values when nothing issues; the stage keeps clocking
  // them but res_valid stays low for those cycles.
  always_comb begin
    op_d         = issue ? head_cmd : op_q;
    op_fire_d    = issue;
    res_valid_d  = op_fire_q;
    res_rotate_d = op_q.rotate;
    issued_d     = issued_q + 8'(issue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      op_fire_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_rotate_q <= 1'b0;
      issued_q     <= '0;
    end else begin
      op_q         <= op_d;
      op_fire_q    <= op_fire_d;
      res_valid_q  <= res_valid_d;
      res_rotate_q <= res_rotate_d;
      issued_q     <= issued_d;
    end
  end

  assign in_ready   = ~full;
  assign op_a       = op_q.a;
  assign op_b       = op_q.b;
  assign op_rotate  = op_q.rotate;
  assign op_fire    = op_fire_q;
  assign res_valid  = res_valid_q;
  assign res_rotate = res_rotate_q;
  assign res_data   = res_in;
  assign issued     = issued_q;

endmodule

// File: tb/tb_rotcnt_issue.sv
// Bench for rotcnt_issue: a cycle model of the FIFO and tag pipeline feeds a
// scoreboard of fired commands whose results are checked as res_valid returns.
module tb_rotcnt_issue;
  import rotcnt_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] a;
    logic [1:0] b;
    logic       r;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [3:0] in_a = '0;
  logic [1:0] in_b = '0;
  logic       in_rotate = 1'b0, issue_en = 1'b0, flush = 1'b0;
  logic [3:0] op_a;
  logic [1:0] op_b;
  logic       op_rotate, op_fire;
  logic [3:0] res_in;
  logic       res_valid, res_rotate;
  logic [3:0] res_data;
  logic [2:0] count;
  logic [7:0] issued;

  int n_checks = 0;
  int n_errors = 0;

  ent_t       fq[$];
  ent_t       sb[$];
  logic       fire_m = 1'b0, rv_m = 1'b0;
  logic [7:0] issued_m = '0;

  always #5 clk = ~clk;

  rotcnt_issue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rotate  (in_rotate),
    .issue_en   (issue_en),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_rotate  (op_rotate),
    .op_fire    (op_fire),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rotate (res_rotate),
    .count      (count),
    .issued     (issued)
  );

  // Downstream stage stand-in: registered R of whatever op_* present.
  logic [3:0] stage_r;
  always @(posedge clk) stage_r <= rotcnt_model(op_a, op_b, op_rotate);
  assign res_in = stage_r;

  function automatic logic [3:0] tb_ref(input logic [3:0] a, input logic [1:0] b, input logic r);
    logic [7:0] t;
    int         k;
    if (r) return a + 4'd1;
    k = (int'(b) + 2) % 4;
    t = {a, a} >> k;
    return t[3:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] a, input logic [1:0] b, input logic r,
                      input logic en, input logic fl);
    logic pop_ok, push_ok;
    ent_t e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_rotate = r;
    issue_en  = en;
    flush     = fl;
    @(posedge clk);
    pop_ok  = (fq.size() != 0) && en && !fl;
    push_ok = v && (fq.size() != DEPTH) && !fl;
    rv_m    = fire_m;
    fire_m  = pop_ok;
    if (fl) fq.delete();
    if (pop_ok) begin
      e = fq.pop_front();
      sb.push_back(e);
      issued_m++;
    end
    if (push_ok) begin
      e.a = a;
      e.b = b;
      e.r = r;
      fq.push_back(e);
    end
    #1;
    check_eq("op_fire", 32'(op_fire), 32'(fire_m));
    check_eq("res_valid", 32'(res_valid), 32'(rv_m));
    check_eq("count", 32'(count), 32'(fq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(fq.size() != DEPTH));
    check_eq("issued", 32'(issued), 32'(issued_m));
    if (fire_m && sb.size() != 0) begin
      check_eq("op_a", 32'(op_a), 32'(sb[$].a));
      check_eq("op_b", 32'(op_b), 32'(sb[$].b));
      check_eq("op_rotate", 32'(op_rotate), 32'(sb[$].r));
    end
    if (rv_m) begin
      check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("res_data", 32'(res_data), 32'(tb_ref(e.a, e.b, e.r)));
        check_eq("res_rotate", 32'(res_rotate), 32'(e.r));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op_fire"}, 32'(op_fire), 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_count"}, 32'(count), 32'd0);
    check_eq({tag, "_issued"}, 32'(issued), 32'd0);
    check_eq({tag, "_op"}, 32'({op_a, op_b, op_rotate}), 32'd0);
    check_eq({tag, "_res_rotate"}, 32'(res_rotate), 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Single command: rotate 0001 right by two.
    step(1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Increment with wrap, then plain increment.
    step(1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'h7, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Four back-to-back commands including the 5-place rotation.
    step(1'b1, 4'b0001, 2'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'b1010, 2'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h3, 2'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b1100, 2'd2, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Backpressure: five pushes with issue held off, then push+pop while full.
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 2), 2'(i), 1'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 9), 2'(i + 1), 1'b0, 1'b1, 1'b0);
    idle(7);

    // Flush while the first of three commands is in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 5), 2'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      step(1'(($urandom % 4) != 0), 4'($urandom), 2'($urandom), 1'($urandom),
           1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0));
    end
    idle(8);

    // Async reset while a command is firing.
    step(1'b1, 4'h6, 2'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h2, 2'd0, 1'b1, 1'b1, 1'b0);
    check_eq("pre_rst_fire", 32'(op_fire), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    fq.delete();
    sb.delete();
    fire_m   = 1'b0;
    rv_m     = 1'b0;
    issued_m = '0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
